// File: rtl/packet_pixel_writer.sv
// Parses a byte stream of {addr_hi, addr_lo, pixel pairs...} packets and issues
// one 12-bit pixel write per completed pixel pair to a video RAM.
module packet_pixel_writer #(
  parameter  int RAM_SIZE  = 1024,
  parameter  int COLOR_LEN = 12,
  localparam int AW        = $clog2(RAM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_vld,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 in_rdy,
  output logic                 ram_write_req,
  output logic [AW-1:0]        ram_write_addr,
  output logic [COLOR_LEN-1:0] ram_write_val,
  input  logic                 ram_write_ready,
  output logic                 pkt_done,
  output logic                 pkt_err
);

  typedef enum logic [1:0] {HDR_HI, HDR_LO, PIX_HI, PIX_LO} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic [7:0]      addr_hi;
  logic [7:0]      pix_hi;
  logic [AW-1:0]   wr_ptr;
  logic [15:0]     hdr_addr;

  assign accept   = in_vld && in_rdy;
  assign hdr_addr = {addr_hi, in_data};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= HDR_HI;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (in_last) begin
        state_nxt = HDR_HI;
      end else begin
        case (state)
          HDR_HI:  state_nxt = HDR_LO;
          HDR_LO:  state_nxt = PIX_HI;
          PIX_HI:  state_nxt = PIX_LO;
          PIX_LO:  state_nxt = PIX_HI;
          default: state_nxt = HDR_HI;
        endcase
      end
    end
  end

  // Only a pixel-completing byte needs the write slot, so only PIX_LO stalls.
  always_comb begin
    in_rdy = !(state == PIX_LO && ram_write_req && !ram_write_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hi        <= '0;
      pix_hi         <= '0;
      wr_ptr         <= '0;
      ram_write_req  <= 1'b0;
      ram_write_addr <= '0;
      ram_write_val  <= '0;
      pkt_done       <= 1'b0;
      pkt_err        <= 1'b0;
    end else begin
      pkt_done <= accept && in_last && (state == PIX_LO);
      pkt_err  <= accept && in_last && (state != PIX_LO);

      if (ram_write_req && ram_write_ready) ram_write_req <= 1'b0;

      if (accept) begin
        case (state)
          HDR_HI: addr_hi <= in_data;
          // A header cut short keeps the previous write pointer.
          HDR_LO: if (!in_last) wr_ptr <= AW'(hdr_addr);
          PIX_HI: pix_hi <= in_data;
          PIX_LO: begin
            // Later assignment wins over the acceptance clear: back-to-back pixels.
            ram_write_req  <= 1'b1;
            ram_write_addr <= wr_ptr;
            ram_write_val  <= COLOR_LEN'({pix_hi, in_data[7:4]});
            wr_ptr         <= wr_ptr + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_pixel_writer.sv
// Directed and randomized-gap bench for packet_pixel_writer: scoreboards every
// accepted RAM write and counts done/err pulses.
module tb_packet_pixel_writer;
  localparam int RAM_SIZE = 1024;
  localparam int AW       = 10;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          reset;
  logic          in_vld;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_rdy;
  logic          ram_write_req;
  logic [AW-1:0] ram_write_addr;
  logic [11:0]   ram_write_val;
  logic          ram_write_ready;
  logic          pkt_done;
  logic          pkt_err;

  packet_pixel_writer #(.RAM_SIZE(RAM_SIZE), .COLOR_LEN(12)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_vld          (in_vld),
    .in_data         (in_data),
    .in_last         (in_last),
    .in_rdy          (in_rdy),
    .ram_write_req   (ram_write_req),
    .ram_write_addr  (ram_write_addr),
    .ram_write_val   (ram_write_val),
    .ram_write_ready (ram_write_ready),
    .pkt_done        (pkt_done),
    .pkt_err         (pkt_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] pack(input int addr, input int val);
    return 32'(addr * 4096 + val);
  endfunction

  // RAM ready: fixed level or random per cycle
  logic rand_rdy  = 1'b0;
  logic rdy_force = 1'b1;
  logic rnd_bit   = 1'b1;
  assign ram_write_ready = rand_rdy ? rnd_bit : rdy_force;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // Monitor: accepted writes, pulses, in_rdy stalls, hold stability
  logic [31:0]   act_q[$];
  int            done_cnt    = 0;
  int            err_cnt     = 0;
  int            both_cnt    = 0;
  int            rdy_low_cnt = 0;
  logic          prev_pend   = 1'b0;
  logic [AW-1:0] prev_addr   = '0;
  logic [11:0]   prev_val    = '0;

  always @(negedge clk) begin
    if (prev_pend) begin
      check("hold_req", 32'(ram_write_req), 32'd1);
      check("hold_addr", 32'(ram_write_addr), 32'(prev_addr));
      check("hold_val", 32'(ram_write_val), 32'(prev_val));
    end
    prev_pend = !reset && ram_write_req && !ram_write_ready;
    prev_addr = ram_write_addr;
    prev_val  = ram_write_val;
    if (!reset) begin
      if (ram_write_req && ram_write_ready)
        act_q.push_back(pack(int'(ram_write_addr), int'(ram_write_val)));
      if (pkt_done) done_cnt++;
      if (pkt_err) err_cnt++;
      if (pkt_done && pkt_err) both_cnt++;
      if (!in_rdy) rdy_low_cnt++;
    end
  end

  // Expected side
  logic [31:0] exp_q[$];
  int          act_base = 0;
  int          exp_done = 0;
  int          exp_err  = 0;
  bit          gaps     = 1'b0;

  task automatic idle_drive();
    in_vld  = 1'b0;
    in_data = 8'($urandom);
    in_last = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit ok = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_vld  = 1'b1;
    in_data = b;
    in_last = last;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk);
      #1;
    end
    if (!ok) check("byte_accept", 32'(ok), 32'd1);
    idle_drive();
  endtask

  task automatic send_pkt(input byte_q_t pkt);
    foreach (pkt[i]) send_byte(pkt[i], i == pkt.size() - 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && ram_write_req; n++) begin
      @(posedge clk);
      #1;
    end
    if (ram_write_req) check("drain", 32'(ram_write_req), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, 32'(act_q.size() - act_base), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (act_base + i < act_q.size()) check({tag, "_wr"}, act_q[act_base + i], exp_q[i]);
    act_base = act_q.size();
    exp_q.delete();
    check({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    byte_q_t pkt;
    int      low0, pulse0;

    reset = 1'b1;
    idle_drive();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(ram_write_req), 32'd0);
    check("rst_addr", 32'(ram_write_addr), 32'd0);
    check("rst_val", 32'(ram_write_val), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_err", 32'(pkt_err), 32'd0);
    check("rst_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;

    // Basic two-pixel packet
    pkt = '{8'h00, 8'h05, 8'hAB, 8'hC0, 8'h12, 8'h3F};
    send_pkt(pkt);
    exp_q.push_back(pack(5, 12'hABC));
    exp_q.push_back(pack(6, 12'h123));
    exp_done++;
    drain();
    compare_writes("basic");

    // Address wrap 0x3FF -> 0 -> 1
    pkt = '{8'h03, 8'hFF, 8'h11, 8'h20, 8'h34, 8'h50, 8'h56, 8'h7F};
    send_pkt(pkt);
    exp_q.push_back(pack(1023, 12'h112));
    exp_q.push_back(pack(0, 12'h345));
    exp_q.push_back(pack(1, 12'h567));
    exp_done++;
    drain();
    compare_writes("wrap");

    // RAM stalls 4 cycles on pixel 1; PIX_HI byte still flows
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB0, 1'b0);
    rdy_force = 1'b0;
    low0 = rdy_low_cnt;
    fork
      begin
        send_byte(8'hC2, 1'b0);
        send_byte(8'hD0, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 rdy_force = 1'b1;
      end
    join
    exp_q.push_back(pack(16, 12'hA1B));
    exp_q.push_back(pack(17, 12'hC2D));
    exp_done++;
    drain();
    check("stall_rdy_low", 32'(rdy_low_cnt - low0), 32'd3);
    compare_writes("stall");

    // Error endings: mid-pixel, header-only, single byte
    pkt = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
    send_pkt(pkt);
    exp_q.push_back(pack(0, 12'h112));
    exp_err++;
    pkt = '{8'h00, 8'h07, 8'h55, 8'h60};
    send_pkt(pkt);
    exp_q.push_back(pack(7, 12'h556));
    exp_done++;
    pkt = '{8'h00, 8'h09};
    send_pkt(pkt);
    exp_err++;
    pkt = '{8'h42};
    send_pkt(pkt);
    exp_err++;
    drain();
    compare_writes("err");

    // Reset while a write is pending
    rdy_force = 1'b0;
    pkt = '{8'h00, 8'h20, 8'hAA, 8'hB0};
    foreach (pkt[i]) send_byte(pkt[i], 1'b0);
    @(negedge clk);
    check("pend_req", 32'(ram_write_req), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_req", 32'(ram_write_req), 32'd0);
    check("abort_addr", 32'(ram_write_addr), 32'd0);
    rdy_force = 1'b1;
    @(posedge clk);
    #1;
    pkt = '{8'h00, 8'h30, 8'hCD, 8'hE0};
    send_pkt(pkt);
    exp_q.push_back(pack(48, 12'hCDE));
    exp_done++;
    drain();
    compare_writes("rst_abort");

    // Random gaps on both sides, 200 packets of mixed endings
    rand_rdy = 1'b1;
    gaps     = 1'b1;
    pulse0   = done_cnt + err_cnt;
    for (int p = 0; p < 200; p++) begin
      logic [15:0] hdr;
      int          kind, npix, base;
      hdr  = 16'($urandom);
      kind = $urandom_range(0, 5);
      npix = (kind == 2) ? $urandom_range(0, 3) : $urandom_range(1, 4);
      base = int'(hdr) % RAM_SIZE;
      pkt.delete();
      pkt.push_back(hdr[15:8]);
      if (kind != 0) pkt.push_back(hdr[7:0]);
      if (kind >= 2) begin
        for (int i = 0; i < npix; i++) begin
          logic [7:0] hi, lo;
          hi = 8'($urandom);
          lo = 8'($urandom);
          pkt.push_back(hi);
          pkt.push_back(lo);
          exp_q.push_back(pack((base + i) % RAM_SIZE, int'(hi) * 16 + int'(lo[7:4])));
        end
      end
      if (kind == 2) pkt.push_back(8'($urandom));
      if (kind >= 3) exp_done++;
      else exp_err++;
      send_pkt(pkt);
    end
    rand_rdy = 1'b0;
    gaps     = 1'b0;
    drain();
    compare_writes("rand");
    check("rand_pkts", 32'(done_cnt + err_cnt - pulse0), 32'd200);
    check("no_overlap", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/packet_pixel_writer.md
PACKET_PIXEL_WRITER -- requirements
Module: packet_pixel_writer

Interface
REQ-001 Parameter RAM_SIZE, default 1024, number of pixel words in the video RAM; SHALL be a power of two; AW = clog2(RAM_SIZE).
REQ-002 Parameter COLOR_LEN, default 12, pixel width; SHALL be fixed at 12.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_vld  in  1  input byte valid.
REQ-006 in_data  in  8  payload byte.
REQ-007 in_last  in  1  marks final byte of packet; qualified by in_vld.
REQ-008 in_rdy  out  1  byte accepted when in_vld && in_rdy at rising clk.
REQ-009 ram_write_req  out  1  write request to video RAM.
REQ-010 ram_write_addr  out  AW  write address.
REQ-011 ram_write_val  out  COLOR_LEN  pixel value.
REQ-012 ram_write_ready  in  1  RAM accepts write when ram_write_req && ram_write_ready at rising clk.
REQ-013 pkt_done  out  1  one-cycle pulse: packet ended cleanly.
REQ-014 pkt_err  out  1  one-cycle pulse: packet ended mid-header or mid-pixel.

Function
REQ-015 Packet format: byte0 = start address high, byte1 = start address low, then 2 bytes per pixel; start address = {byte0, byte1} mod RAM_SIZE.
REQ-016 Pixel = {first byte[7:0], second byte[7:4]}; second byte[3:0] discarded.
REQ-017 FSM states: HDR_HI, HDR_LO, PIX_HI, PIX_LO; reset state HDR_HI.
REQ-018 Transitions on accepted byte without in_last: HDR_HI->HDR_LO, HDR_LO->PIX_HI, PIX_HI->PIX_LO, PIX_LO->PIX_HI.
REQ-019 Any accepted byte with in_last SHALL return FSM to HDR_HI.
REQ-020 in_last accepted in PIX_LO: pixel written, pkt_done pulses next cycle.
REQ-021 in_last accepted in HDR_HI, HDR_LO or PIX_HI: no write issued, partial data dropped, pkt_err pulses next cycle; write address register unchanged.
REQ-022 Header-only packet (in_last on byte1) counts as error per REQ-021.
REQ-023 Byte accepted in PIX_LO: ram_write_req, ram_write_addr, ram_write_val SHALL be registered and valid the following cycle (latency 1).
REQ-024 ram_write_req, addr and val SHALL hold stable until the write is accepted; req deasserts the cycle after acceptance unless a new pixel is loaded the same edge.
REQ-025 After each issued write, the address register increments by 1 mod RAM_SIZE (RAM_SIZE-1 wraps to 0).
REQ-026 in_rdy = !(state == PIX_LO && ram_write_req && !ram_write_ready); in_rdy is high in all other cases, so header and PIX_HI bytes flow during a pending write.
REQ-027 Write accepted and new PIX_LO byte accepted on the same edge: new pixel loaded, req stays high, no bubble.
REQ-028 pkt_done and pkt_err SHALL never assert in the same cycle.
REQ-029 in_data and in_last are ignored when in_vld is low; FSM holds state.

Reset
REQ-030 On reset: state HDR_HI, ram_write_req 0, ram_write_addr 0, ram_write_val 0, pkt_done 0, pkt_err 0; in_rdy high the cycle after reset deasserts.
REQ-031 Reset asserted mid-packet or while a write is pending SHALL abort the write (req 0 next cycle) with no pkt_done/pkt_err pulse; subsequent bytes are parsed as a new header.

Verification
REQ-032 Packet 0x00,0x05,0xAB,0xC0,0x12,0x3F(last), ready tied 1 -> writes addr 5 val 0xABC, addr 6 val 0x123; pkt_done one pulse; no pkt_err.
REQ-033 Header 0x03,0xFF, 3 pixels, RAM_SIZE 1024 -> writes to addresses 1023, 0, 1 in order.
REQ-034 ram_write_ready held 0 for 4 cycles during pixel 1 -> req/addr/val stable, in_rdy low only in PIX_LO, no byte lost; all pixels written once.
REQ-035 Packet 0x00,0x00,0x11,0x22,0x33(last) -> one write (addr 0, 0x112), pkt_err one pulse, next packet header decoded correctly.
REQ-036 Reset pulsed while write pending -> req 0 next cycle, no pulses, next packet starts at its own header address.
REQ-037 Random in_vld/ram_write_ready gaps, 200 packets -> scoreboard matches every (addr, val) write exactly, pkt_done+pkt_err count equals packet count.
